alu_issue_ctrl: RTL and testbench

Initiator side of the datapath ALU interface. It accepts 16-bit instruction words over a valid/ready handshake and decodes each one. It reads operands from an internal 8x32 register file, drives A/B/ALUOp to the external combinational ALU, captures the returned C, and writes it back. It sits between the instruction source and the ALU and is the only producer of ALUOp.

---
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the datapath ALU: accepts instructions, reads operands
// from an 8x32 register file, drives the external ALU and writes results back.
module alu_issue_ctrl #(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_c,
    output logic          wb_valid,
    output logic [2:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          err,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int unsigned IMMW = 7;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic          accept_c;
    logic [2:0]    op_q;
    logic [2:0]    rd_q;
    logic [DW-1:0] regs [NREG];

    logic [2:0]      in_op;
    logic [2:0]      in_rd;
    logic [2:0]      in_rs;
    logic [2:0]      in_rt;
    logic [IMMW-1:0] in_imm;

    assign in_op  = in_instr[15:13];
    assign in_rd  = in_instr[12:10];
    assign in_rs  = in_instr[9:7];
    assign in_rt  = in_instr[6:4];
    assign in_imm = in_instr[6:0];

    assign accept_c = (state == S_IDLE) && in_valid && in_ready;
    assign dbg_data = regs[dbg_addr];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the sequence is fixed with no stall path
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept_c) next_state = S_EXEC;
            S_EXEC:  next_state = S_WB;
            S_WB:    next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Operands are read at the accept edge; every earlier writeback has already
    // landed by then, so this matches reading them during EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b1;
            op_q     <= '0;
            rd_q     <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            err      <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (accept_c) begin
                in_ready <= 1'b0;
                op_q     <= in_op;
                rd_q     <= in_rd;
                if (in_op == OP_LDI) begin
                    alu_a  <= '0;
                    alu_b  <= DW'(in_imm);
                    alu_op <= 3'd0;
                end else begin
                    alu_a  <= regs[in_rs];
                    alu_b  <= regs[in_rt];
                    alu_op <= in_op;
                end
            end
            if (state == S_EXEC) begin
                wb_data  <= alu_c;
                wb_addr  <= rd_q;
                wb_valid <= (op_q != OP_ILL);
                err      <= (op_q == OP_ILL);
            end
            if (state == S_WB) begin
                wb_valid <= 1'b0;
                err      <= 1'b0;
                in_ready <= 1'b1;
                // r0 is hardwired to zero
                if ((op_q != OP_ILL) && (rd_q != 3'd0)) begin
                    regs[rd_q] <= wb_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural combinational ALU.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    typedef struct {
        logic        is_err;
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          wb_t[$];
    int          acc_t[$];
    logic [31:0] mreg [8];
    int          n_checks = 0;
    int          n_errors = 0;

    alu_issue_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_c    (alu_c),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            3'd0:    alu_c = alu_a + alu_b;
            3'd1:    alu_c = alu_a - alu_b;
            3'd2:    alu_c = alu_a & alu_b;
            3'd3:    alu_c = alu_a | alu_b;
            3'd4:    alu_c = alu_a >> alu_b;
            3'd5:    alu_c = 32'($signed(alu_a) >>> alu_b);
            default: alu_c = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [6:0] imm);
        if (op == 3'd6) return {op, rd, 3'b000, imm};
        return {op, rd, rs, rt, 4'b0000};
    endfunction

    // Reference result of an instruction against the model register file
    task automatic sb_push(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic [6:0] imm,
                           output logic [31:0] ea, output logic [31:0] eb);
        logic [31:0] res;
        exp_t e;
        ea = (op == 3'd6) ? 32'd0 : mreg[rs];
        eb = (op == 3'd6) ? {25'd0, imm} : mreg[rt];
        case (op)
            3'd0:    res = ea + eb;
            3'd1:    res = ea - eb;
            3'd2:    res = ea & eb;
            3'd3:    res = ea | eb;
            3'd4:    res = (eb > 32'd31) ? 32'd0 : (ea >> eb[4:0]);
            3'd5:    res = (eb > 32'd31) ? {32{ea[31]}} : 32'($signed(ea) >>> eb[4:0]);
            3'd6:    res = {25'd0, imm};
            default: res = 32'd0;
        endcase
        e.is_err = (op == 3'd7);
        e.addr   = rd;
        e.data   = res;
        sbq.push_back(e);
        if (op != 3'd7 && rd != 3'd0) mreg[rd] = res;
    endtask

    // Writeback monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (wb_valid || err) begin
            wb_t.push_back(int'($time));
            if (sbq.size() == 0) begin
                check("unexpected_pulse", {30'd0, wb_valid, err}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("wb_valid", {31'd0, wb_valid}, {31'd0, !e.is_err});
                check("err", {31'd0, err}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    check("wb_addr", {29'd0, wb_addr}, {29'd0, e.addr});
                    check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    // Issue one instruction; returns at the negedge inside EXEC, or in IDLE after WB
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [6:0] imm, input bit push,
                         input bit wait_wb);
        logic [31:0] ea, eb;
        ea = (op == 3'd6) ? 32'd0 : mreg[rs];
        eb = (op == 3'd6) ? {25'd0, imm} : mreg[rt];
        if (push) sb_push(op, rd, rs, rt, imm, ea, eb);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc(op, rd, rs, rt, imm);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("exec_alu_op", {29'd0, alu_op}, (op == 3'd6) ? 32'd0 : {29'd0, op});
        check("exec_alu_a", alu_a, ea);
        check("exec_alu_b", alu_b, eb);
        check("exec_ready", {31'd0, in_ready}, 32'd0);
        check("exec_no_wb", {31'd0, wb_valid | err}, 32'd0);
        if (wait_wb) begin
            @(negedge clk);
            check("wb_latency", {31'd0, wb_valid | err}, 32'd1);
            @(negedge clk);
            check("idle_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic chk_reg(input logic [2:0] r, input string tag);
        dbg_addr = r;
        #1;
        check(tag, dbg_data, mreg[r]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  p_op [4];
        logic [2:0]  p_rd [4];
        logic [2:0]  p_rs [4];
        logic [2:0]  p_rt [4];
        logic [6:0]  p_im [4];
        logic [31:0] ea, eb;
        int          k;

        for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'd0;
        dbg_addr = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_alu_op", {29'd0, alu_op}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        reset = 1'b0;
        for (int r = 0; r < 8; r++) chk_reg(3'(r), "rst_reg");

        // Load-immediate
        issue(3'd6, 3'd1, 3'd0, 3'd0, 7'h7F, 1'b1, 1'b1);
        chk_reg(3'd1, "ldi_r1");

        // Add/sub with carry into bit 7 and negative wrap
        issue(3'd6, 3'd2, 3'd0, 3'd0, 7'h01, 1'b1, 1'b1);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 7'h00, 1'b1, 1'b1);
        chk_reg(3'd3, "add_r3");
        issue(3'd1, 3'd4, 3'd2, 3'd1, 7'h00, 1'b1, 1'b1);
        chk_reg(3'd4, "sub_r4");
        check("sub_value", mreg[4], 32'hFFFF_FF82);

        // Logical and arithmetic right shifts
        issue(3'd6, 3'd5, 3'd0, 3'd0, 7'h7F, 1'b1, 1'b1);
        issue(3'd6, 3'd6, 3'd0, 3'd0, 7'h01, 1'b1, 1'b1);
        issue(3'd4, 3'd7, 3'd5, 3'd6, 7'h00, 1'b1, 1'b1);
        chk_reg(3'd7, "srl_r7");
        issue(3'd5, 3'd7, 3'd4, 3'd6, 7'h00, 1'b1, 1'b1);
        chk_reg(3'd7, "sra_r7");
        check("sra_value", mreg[7], 32'hFFFF_FFC1);

        // Back-to-back with in_valid held high
        p_op = '{3'd6, 3'd0, 3'd1, 3'd3};
        p_rd = '{3'd1, 3'd2, 3'd3, 3'd4};
        p_rs = '{3'd0, 3'd1, 3'd1, 3'd2};
        p_rt = '{3'd0, 3'd1, 3'd2, 3'd1};
        p_im = '{7'h10, 7'h00, 7'h00, 7'h00};
        wb_t.delete();
        acc_t.delete();
        k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc(p_op[0], p_rd[0], p_rs[0], p_rt[0], p_im[0]);
        for (int c = 0; c < 40 && k < 4; c++) begin
            if (in_ready) begin
                sb_push(p_op[k], p_rd[k], p_rs[k], p_rt[k], p_im[k], ea, eb);
                @(posedge clk);
                acc_t.push_back(int'($time));
                k++;
                #1;
                if (k < 4) in_instr = enc(p_op[k], p_rd[k], p_rs[k], p_rt[k], p_im[k]);
                else in_valid = 1'b0;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", k, 32'd4);
        repeat (3) @(negedge clk);
        check("b2b_wb_count", wb_t.size(), 32'd4);
        for (int i = 1; i < acc_t.size(); i++)
            check("b2b_acc_gap", 32'(acc_t[i] - acc_t[i-1]), 32'd30);
        for (int i = 1; i < wb_t.size(); i++)
            check("b2b_wb_gap", 32'(wb_t[i] - wb_t[i-1]), 32'd30);
        for (int r = 1; r < 5; r++) chk_reg(3'(r), "b2b_reg");
        check("b2b_r3_value", mreg[3], 32'hFFFF_FFF0);

        // Write to r0 pulses wb_valid but leaves r0 at zero
        issue(3'd6, 3'd0, 3'd0, 3'd0, 7'h05, 1'b1, 1'b1);
        chk_reg(3'd0, "r0_zero");

        // Illegal op: err pulse, no register change
        issue(3'd7, 3'd1, 3'd2, 3'd3, 7'h00, 1'b1, 1'b1);
        for (int r = 0; r < 8; r++) chk_reg(3'(r), "ill_reg");

        // Reset during EXEC drops the instruction
        issue(3'd0, 3'd3, 3'd1, 3'd2, 7'h00, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        chk_reg(3'd3, "midrst_r3");
        repeat (4) @(negedge clk);

        check("sb_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
